mem_wb_debug_reader: RTL and testbench

- Debug-side reader for the MEM/WB pipeline register.
- On request, the block issues a one-cycle step pulse to the pipeline latches, or skips the step.
- It then snapshots the MEM/WB latch outputs and streams them as a fixed byte frame over a valid/ready byte interface to the UART TX path.
- It sits between the debug command decoder and the UART transmitter.

---
 rtl/mem_wb_debug_reader_pkg.sv | 55 +++++
 rtl/mem_wb_debug_reader_serializer.sv | 79 +++++++
 rtl/mem_wb_debug_reader.sv | 101 ++++++++++
 tb/tb_mem_wb_debug_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_debug_reader_pkg.sv
// Shared debug definitions for latch readers: FSM encoding, frame layout, header default.
// Frame length depends on MEMWB_DUMP_CKSUM_EN (14 bytes, or 15 with trailing XOR checksum).
// No logic here; consumers include the RTL readers and the host-side frame decoder.
package mem_wb_debug_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_WAIT,
    ST_SNAP,
    ST_SEND,
    ST_DONE
  } dbg_state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN_BASE      = 14;
  localparam int         FRAME_LEN_CKSUM     = 15;
`ifdef MEMWB_DUMP_CKSUM_EN
  localparam int         FRAME_LEN           = FRAME_LEN_CKSUM;
`else
  localparam int         FRAME_LEN           = FRAME_LEN_BASE;
`endif
  localparam logic [3:0] LAST_IDX            = 4'(FRAME_LEN - 1);

  // Byte offsets inside the frame, shared with the host decoder.
  localparam logic [3:0] OFS_HEADER     = 4'd0;
  localparam logic [3:0] OFS_OUTPUT_MEM = 4'd1;
  localparam logic [3:0] OFS_ALU_RES    = 4'd5;
  localparam logic [3:0] OFS_PC_TO_REG  = 4'd9;
  localparam logic [3:0] OFS_CTRL       = 4'd13;
  localparam logic [3:0] OFS_CKSUM      = 4'd14;

  typedef struct packed {
    logic [31:0] output_mem;
    logic [31:0] alu_res;
    logic [31:0] pc_to_reg;
    logic [4:0]  addr_reg_dst;
    logic        write_pc;
    logic        reg_write;
    logic        mem_to_reg;
  } memwb_snap_t;

  // sel 0 selects the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_wb_debug_reader_serializer.sv
// Byte-frame serializer for a MEM/WB snapshot; optional checksum under MEMWB_DUMP_CKSUM_EN.
// Header valid the cycle after start; one byte per cycle when tx_ready stays high.
// Holds tx_data/tx_valid while tx_ready is low; tx_valid never depends on tx_ready.
module memwb_frame_serializer
  import mem_wb_debug_reader_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  memwb_snap_t snap,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_xfer
);

  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic [7:0] byte_nxt;
  logic [7:0] ctrl_byte;
  logic       xfer;

  assign xfer      = tx_valid && tx_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign idx_nxt   = idx + 4'd1;
  assign ctrl_byte = {snap.addr_reg_dst, snap.write_pc, snap.reg_write, snap.mem_to_reg};

`ifdef MEMWB_DUMP_CKSUM_EN
  logic [7:0] cksum;
  always_comb begin
    cksum = ctrl_byte;
    for (int i = 0; i < 4; i++) begin
      cksum = cksum ^ word_byte(snap.output_mem, 2'(i))
                    ^ word_byte(snap.alu_res, 2'(i))
                    ^ word_byte(snap.pc_to_reg, 2'(i));
    end
  end
`endif

  // Byte presented after the current one transfers.
  always_comb begin
    byte_nxt = 8'h00;
    if (idx_nxt == OFS_CTRL)
      byte_nxt = ctrl_byte;
`ifdef MEMWB_DUMP_CKSUM_EN
    else if (idx_nxt == OFS_CKSUM)
      byte_nxt = cksum;
`endif
    else if (idx_nxt >= OFS_PC_TO_REG)
      byte_nxt = word_byte(snap.pc_to_reg, 2'(idx_nxt - OFS_PC_TO_REG));
    else if (idx_nxt >= OFS_ALU_RES)
      byte_nxt = word_byte(snap.alu_res, 2'(idx_nxt - OFS_ALU_RES));
    else if (idx_nxt >= OFS_OUTPUT_MEM)
      byte_nxt = word_byte(snap.output_mem, 2'(idx_nxt - OFS_OUTPUT_MEM));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= OFS_HEADER;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (start) begin
      idx      <= OFS_HEADER;
      tx_valid <= 1'b1;
      tx_data  <= HEADER_BYTE;
    end else if (xfer) begin
      if (idx == LAST_IDX) begin
        tx_valid <= 1'b0;
        tx_data  <= 8'h00;
      end else begin
        idx     <= idx_nxt;
        tx_data <= byte_nxt;
      end
    end
  end

endmodule

// File: rtl/mem_wb_debug_reader.sv
// MEM/WB debug reader: optional step pulse, snapshot, byte-frame dump (MEMWB_DUMP_CKSUM_EN adds checksum).
// Step req cycle 0 -> o_step cycle 1, header valid cycle 4; dump req cycle 0 -> header valid cycle 2.
// Frame stalls on i_tx_ready low; requests while busy are dropped, not queued.
module mem_wb_debug_reader
  import mem_wb_debug_reader_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
  parameter int         AUTO_DUMP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_step_req,
  input  logic        i_dump_req,
  input  logic [31:0] i_output_mem,
  input  logic [31:0] i_ALU_res,
  input  logic [31:0] i_pc_to_reg,
  input  logic [4:0]  i_addr_reg_dst,
  input  logic        is_write_pc,
  input  logic        is_RegWrite,
  input  logic        is_MemtoReg,
  input  logic        i_tx_ready,
  output logic        o_step,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_busy,
  output logic        o_done
);

  dbg_state_t  state_q, state_nxt;
  memwb_snap_t snap_q;
  logic        last_xfer;
  logic        step_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_step_req)      state_nxt = ST_STEP;
        else if (i_dump_req) state_nxt = ST_SNAP;
      end
      ST_STEP: state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = (AUTO_DUMP != 0) ? ST_SNAP : ST_DONE;
      ST_SNAP: state_nxt = ST_SEND;
      ST_SEND: if (last_xfer) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    step_nxt = (state_nxt == ST_STEP);
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_step <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_step <= step_nxt;
      o_busy <= busy_nxt;
      o_done <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q <= '0;
    end else if (state_q == ST_SNAP) begin
      snap_q <= '{output_mem:   i_output_mem,
                  alu_res:      i_ALU_res,
                  pc_to_reg:    i_pc_to_reg,
                  addr_reg_dst: i_addr_reg_dst,
                  write_pc:     is_write_pc,
                  reg_write:    is_RegWrite,
                  mem_to_reg:   is_MemtoReg};
    end
  end

  memwb_frame_serializer #(
    .HEADER_BYTE(HEADER_BYTE)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .start    (state_q == ST_SNAP),
    .snap     (snap_q),
    .tx_ready (i_tx_ready),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .last_xfer(last_xfer)
  );

endmodule

// File: tb/tb_mem_wb_debug_reader.sv
// Bench for mem_wb_debug_reader: directed and randomized operations against a frame-level model.
module tb_mem_wb_debug_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_step_req, i_dump_req;
  logic [31:0] i_output_mem, i_ALU_res, i_pc_to_reg;
  logic [4:0]  i_addr_reg_dst;
  logic        is_write_pc, is_RegWrite, is_MemtoReg;
  logic        i_tx_ready;
  logic        o_step, o_tx_valid, o_busy, o_done;
  logic [7:0]  o_tx_data;

  mem_wb_debug_reader dut (
    .clk           (clk),
    .rst           (rst),
    .i_step_req    (i_step_req),
    .i_dump_req    (i_dump_req),
    .i_output_mem  (i_output_mem),
    .i_ALU_res     (i_ALU_res),
    .i_pc_to_reg   (i_pc_to_reg),
    .i_addr_reg_dst(i_addr_reg_dst),
    .is_write_pc   (is_write_pc),
    .is_RegWrite   (is_RegWrite),
    .is_MemtoReg   (is_MemtoReg),
    .i_tx_ready    (i_tx_ready),
    .o_step        (o_step),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model copy of the latch values the frame must carry.
  logic [31:0] m_mem, m_alu, m_pc;
  logic [4:0]  m_addr;
  logic        m_wpc, m_rw, m_m2r;
  logic [7:0]  exp_frame[$];

  // Observations of the last operation.
  logic [7:0]  got[$];
  int          step_cyc[$];
  int          hdr_cyc, done_cnt, done_cyc, last_xfer_cyc, bad_stall;
  logic        end_busy, end_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic drive_inputs(input logic [31:0] mem, input logic [31:0] alu, input logic [31:0] pc,
                              input logic [4:0] addr, input logic wpc, input logic rw, input logic m2r);
    i_output_mem = mem;  i_ALU_res = alu;  i_pc_to_reg = pc;
    i_addr_reg_dst = addr;  is_write_pc = wpc;  is_RegWrite = rw;  is_MemtoReg = m2r;
    m_mem = mem;  m_alu = alu;  m_pc = pc;  m_addr = addr;  m_wpc = wpc;  m_rw = rw;  m_m2r = m2r;
  endtask

  task automatic drive_random();
    drive_inputs($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic model_frame();
    logic [31:0] words[3];
    logic [7:0]  x;
    words = '{m_mem, m_alu, m_pc};
    exp_frame.delete();
    exp_frame.push_back(8'hA5);
    for (int w = 0; w < 3; w++)
      for (int b = 3; b >= 0; b--)
        exp_frame.push_back(words[w][8*b +: 8]);
    exp_frame.push_back({m_addr, m_wpc, m_rw, m_m2r});
`ifdef MEMWB_DUMP_CKSUM_EN
    x = 8'h00;
    for (int k = 1; k <= 13; k++) x = x ^ exp_frame[k];
    exp_frame.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  // rmode: 0 ready always, 1 ready pattern 0,0,1 per byte, 2 random ready.
  task automatic run_op(input logic do_step, input logic do_dump, input int rmode,
                        input bit mid_req, input int chg_cycle, input int abort_after);
    logic       stall, r, injected;
    logic [7:0] prev_data;
    int         pat;
    got.delete();  step_cyc.delete();
    hdr_cyc = -1;  done_cnt = 0;  done_cyc = -1;  last_xfer_cyc = -1;  bad_stall = 0;
    stall = 1'b0;  injected = 1'b0;  pat = 0;  prev_data = 8'h00;
    @(posedge clk); #1;
    i_step_req = do_step;  i_dump_req = do_dump;  i_tx_ready = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      i_step_req = 1'b0;  i_dump_req = 1'b0;
      if (o_step) step_cyc.push_back(cyc);
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (stall && !(o_tx_valid === 1'b1 && o_tx_data === prev_data)) bad_stall++;
      if (o_tx_valid && hdr_cyc < 0) hdr_cyc = cyc;
      if (cyc == chg_cycle) begin
        i_output_mem = $urandom;  i_ALU_res = $urandom;  i_pc_to_reg = $urandom;
        i_addr_reg_dst = ~m_addr;  is_write_pc = ~m_wpc;  is_RegWrite = ~m_rw;  is_MemtoReg = ~m_m2r;
      end
      if (mid_req && !injected && o_tx_valid && got.size() == 3) begin
        i_step_req = 1'b1;  i_dump_req = 1'b1;  injected = 1'b1;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = o_tx_valid && (pat == 2);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (rmode == 1 && o_tx_valid) pat = r ? 0 : pat + 1;
      i_tx_ready = r;
      stall = o_tx_valid && !r;
      prev_data = o_tx_data;
      if (o_tx_valid && r) begin
        got.push_back(o_tx_data);
        last_xfer_cyc = cyc;
      end
      if (abort_after > 0 && got.size() == abort_after) return;
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
    end
    end_busy = o_busy;
    end_valid = o_tx_valid;
  endtask

  task automatic check_op(input string tag, input int exp_hdr, input int exp_steps);
    model_frame();
    check({tag, "_frame_len"}, got.size(), exp_frame.size());
    for (int k = 0; k < exp_frame.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), (k < got.size()) ? got[k] : 8'hxx, exp_frame[k]);
    check({tag, "_hdr_cycle"}, hdr_cyc, exp_hdr);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_after_last"}, done_cyc, last_xfer_cyc + 1);
    check({tag, "_step_count"}, step_cyc.size(), exp_steps);
    if (exp_steps > 0) check({tag, "_step_cycle"}, step_cyc[0], 1);
    check({tag, "_stall_hold"}, bad_stall, 0);
    check({tag, "_idle_busy"}, end_busy, 1'b0);
    check({tag, "_idle_valid"}, end_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;  i_step_req = 1'b0;  i_dump_req = 1'b0;  i_tx_ready = 1'b0;
    drive_inputs('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rst_step", o_step, 1'b0);
    check("rst_valid", o_tx_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_data", o_tx_data, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Fixed-value dump at full rate.
    drive_inputs(32'h11223344, 32'hAABBCCDD, 32'h00000040, 5'd31, 1'b1, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 0, 1'b0, 0, 0);
    check_op("dump", 2, 0);
    check("dump_ctrl_fe", (got.size() > 13) ? got[13] : 8'hxx, 8'hFE);
    check("dump_done_cycle", done_cyc, 2 + exp_frame.size());

    // Step with auto dump; inputs change in cycle 5 after the snapshot.
    drive_random();
    run_op(1'b1, 1'b0, 0, 1'b0, 5, 0);
    check_op("step", 4, 1);

    // Backpressure 0,0,1 per byte.
    drive_random();
    run_op(1'b0, 1'b1, 1, 1'b0, 0, 0);
    check_op("bp", 2, 0);

    // Simultaneous step+dump, plus both requests again mid-frame.
    drive_random();
    run_op(1'b1, 1'b1, 0, 1'b1, 0, 0);
    check_op("both", 4, 1);

    // Asynchronous reset after byte 5, then a fresh dump.
    drive_random();
    run_op(1'b0, 1'b1, 0, 1'b0, 0, 6);
    check("abort_pre_valid", o_tx_valid, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort_valid", o_tx_valid, 1'b0);
    check("abort_data", o_tx_data, 8'h00);
    check("abort_busy", o_busy, 1'b0);
    check("abort_step", o_step, 1'b0);
    check("abort_done", o_done, 1'b0);
    #20 rst = 1'b1;
    drive_random();
    run_op(1'b0, 1'b1, 0, 1'b0, 0, 0);
    check_op("post_rst", 2, 0);

    // Random operations with random ready.
    for (int n = 0; n < 6; n++) begin
      logic s, d;
      s = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!s) d = 1'b1;
      drive_random();
      run_op(s, d, 2, 1'($urandom_range(0, 1)), 0, 0);
      check_op($sformatf("rnd%0d", n), s ? 4 : 2, s ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
